// File: rtl/fp32_pkg.sv
// Shared IEEE754 single-precision types and helpers for the FPU datapath blocks.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7fc00000;
  localparam int unsigned FP32_BIAS = 127;
  localparam int unsigned FP32_MANT_W = 24;
  localparam int unsigned FP32_PROD_W = 48;
  localparam int unsigned FP32_EXP_W = 10;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp32_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_ROUND,
    ST_DONE
  } fp32_state_t;

  // Classified operand; mant is left-justified (bit 23 set for any nonzero finite value).
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        sub;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [23:0] mant;
    logic [4:0]  lz;
  } fp32_unpacked_t;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational operand classification and subnormal prenormalization.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]    i_x,
  output fp32_unpacked_t o_u
);

  fp32_t       w_f;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_frac_nz;
  logic [23:0] w_raw;
  logic [4:0]  w_lz;

  assign w_f        = i_x;
  assign w_exp_zero = (w_f.exp == 8'h00);
  assign w_exp_ones = (w_f.exp == 8'hff);
  assign w_frac_nz  = |w_f.frac;
  assign w_raw      = {~w_exp_zero, w_f.frac};
  assign w_lz       = lzc24(w_raw);

  always_comb begin
    o_u      = '0;
    o_u.sign = w_f.sign;
    o_u.exp  = w_f.exp;
    o_u.frac = w_f.frac;
    o_u.zero = w_exp_zero & ~w_frac_nz;
    o_u.sub  = w_exp_zero & w_frac_nz;
    o_u.inf  = w_exp_ones & ~w_frac_nz;
    o_u.nan  = w_exp_ones & w_frac_nz;
    o_u.snan = w_exp_ones & w_frac_nz & ~w_f.frac[22];
    o_u.lz   = w_lz;
    o_u.mant = w_raw << w_lz;
  end

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle IEEE754 single-precision multiplier with a shift-add product array,
// round-to-nearest-even, subnormal support and valid/ready handshakes on both sides.
module fp32_mul_seq
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        exc_invalid,
  output logic        exc_overflow,
  output logic        exc_underflow,
  output logic        exc_inexact,
  output logic        busy
);

  localparam int unsigned BPC   = BITS_PER_CYCLE;
  localparam int unsigned NCYC  = (BPC == 0) ? 1 : FP32_MANT_W / BPC;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PW    = FP32_PROD_W;
  localparam int unsigned EW    = FP32_EXP_W;

  if (!(BPC == 1 || BPC == 2 || BPC == 3 || BPC == 4 || BPC == 6 ||
        BPC == 8 || BPC == 12 || BPC == 24)) begin : g_bad_bpc
    $error("fp32_mul_seq: illegal BITS_PER_CYCLE %0d", BPC);
  end

  fp32_state_t        r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [31:0]        r_y;
  fp32_flags_t        r_flags;
  logic               r_sign;
  logic signed [EW-1:0] r_exp;
  logic [PW-1:0]      r_mcand;
  logic [23:0]        r_mplier;
  logic [PW-1:0]      r_prod;
  logic [CNT_W-1:0]   r_cnt;

  fp32_unpacked_t     w_ua;
  fp32_unpacked_t     w_ub;
  logic               w_sign;
  logic [EW-1:0]      w_ea;
  logic [EW-1:0]      w_eb;
  logic signed [EW-1:0] w_exp_in;
  logic               w_special;
  fp32_t              w_spec_y;
  fp32_flags_t        w_spec_flags;
  logic [PW-1:0]      w_partial;

  fp32_unpack u_unpack_a (.i_x(a), .o_u(w_ua));
  fp32_unpack u_unpack_b (.i_x(b), .o_u(w_ub));

  // Subnormals contribute an effective biased exponent of 1 before the leading-zero shift.
  assign w_sign   = w_ua.sign ^ w_ub.sign;
  assign w_ea     = w_ua.sub ? EW'(1) : EW'(w_ua.exp);
  assign w_eb     = w_ub.sub ? EW'(1) : EW'(w_ub.exp);
  assign w_exp_in = w_ea + w_eb - EW'(FP32_BIAS) - EW'(w_ua.lz) - EW'(w_ub.lz);

  assign w_partial = PW'(r_mcand * PW'(r_mplier[BPC-1:0]));

  // Special-operand results, highest priority first.
  always_comb begin
    w_special    = 1'b0;
    w_spec_y     = '0;
    w_spec_flags = '0;
    if (w_ua.nan || w_ub.nan) begin
      w_special            = 1'b1;
      w_spec_y             = w_ua.nan ? {w_ua.sign, 8'hff, w_ua.frac | 23'h400000}
                                      : {w_ub.sign, 8'hff, w_ub.frac | 23'h400000};
      w_spec_flags.invalid = w_ua.snan | w_ub.snan;
    end else if ((w_ua.inf && w_ub.zero) || (w_ua.zero && w_ub.inf)) begin
      w_special            = 1'b1;
      w_spec_y             = FP32_QNAN;
      w_spec_flags.invalid = 1'b1;
    end else if (w_ua.inf || w_ub.inf) begin
      w_special = 1'b1;
      w_spec_y  = {w_sign, 8'hff, 23'd0};
    end else if (w_ua.zero || w_ub.zero) begin
      w_special = 1'b1;
      w_spec_y  = {w_sign, 8'h00, 23'd0};
    end
  end

  logic signed [EW-1:0] w_e1;
  logic signed [EW-1:0] w_e2;
  logic signed [EW-1:0] w_sh_full;
  logic [23:0]        w_mant;
  logic               w_g;
  logic               w_st;
  logic               w_tiny;
  logic [4:0]         w_sh;
  logic [25:0]        w_vec;
  logic [25:0]        w_vsh;
  logic [25:0]        w_mask;
  logic               w_lost;
  logic [23:0]        w_m2;
  logic               w_g2;
  logic               w_st2;
  logic               w_inc;
  logic [24:0]        w_rnd;
  logic               w_inexact;
  logic [22:0]        w_frac_n;
  fp32_t              w_rnd_y;
  fp32_flags_t        w_rnd_flags;

  // Normalize, denormalize if tiny, round to nearest even, then range-check.
  always_comb begin
    w_e1        = r_exp;
    w_mant      = r_prod[46:23];
    w_g         = r_prod[22];
    w_st        = |r_prod[21:0];
    if (r_prod[47]) begin
      w_e1   = r_exp + 10'sd1;
      w_mant = r_prod[47:24];
      w_g    = r_prod[23];
      w_st   = |r_prod[22:0];
    end
    w_tiny      = (w_e1 <= 10'sd0);
    w_sh_full   = 10'sd1 - w_e1;
    w_sh        = 5'd0;
    if (w_tiny) w_sh = (w_sh_full > 10'sd26) ? 5'd26 : w_sh_full[4:0];
    w_vec       = {w_mant, w_g, w_st};
    w_mask      = ~(26'h3ffffff << w_sh);
    w_lost      = |(w_vec & w_mask);
    w_vsh       = w_vec >> w_sh;
    w_m2        = w_vsh[25:2];
    w_g2        = w_vsh[1];
    w_st2       = w_vsh[0] | w_lost;
    w_inc       = w_g2 & (w_st2 | w_m2[0]);
    w_rnd       = {1'b0, w_m2} + 25'(w_inc);
    w_inexact   = w_g2 | w_st2;
    w_e2        = w_rnd[24] ? (w_e1 + 10'sd1) : w_e1;
    w_frac_n    = w_rnd[24] ? 23'd0 : w_rnd[22:0];
    w_rnd_y     = '0;
    w_rnd_flags = '0;
    if (w_tiny) begin
      w_rnd_y               = {r_sign, {7'd0, w_rnd[23]}, w_rnd[22:0]};
      w_rnd_flags.underflow = w_inexact;
      w_rnd_flags.inexact   = w_inexact;
    end else if (w_e2 > 10'sd254) begin
      w_rnd_y              = {r_sign, 8'hff, 23'd0};
      w_rnd_flags.overflow = 1'b1;
      w_rnd_flags.inexact  = 1'b1;
    end else begin
      w_rnd_y             = {r_sign, w_e2[7:0], w_frac_n};
      w_rnd_flags.inexact = w_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_y         <= '0;
      r_flags     <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_sign;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_y         <= w_spec_y;
              r_flags     <= w_spec_flags;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_exp    <= w_exp_in;
              r_mcand  <= PW'(w_ua.mant);
              r_mplier <= w_ub.mant;
              r_prod   <= '0;
              r_cnt    <= CNT_W'(NCYC - 1);
              r_state  <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_prod   <= r_prod + w_partial;
          r_mcand  <= r_mcand << BPC;
          r_mplier <= r_mplier >> BPC;
          if (r_cnt == '0) r_state <= ST_ROUND;
          else r_cnt <= CNT_W'(r_cnt - CNT_W'(1));
        end
        ST_ROUND: begin
          r_y         <= w_rnd_y;
          r_flags     <= w_rnd_flags;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign y             = r_y;
  assign exc_invalid   = r_flags.invalid;
  assign exc_overflow  = r_flags.overflow;
  assign exc_underflow = r_flags.underflow;
  assign exc_inexact   = r_flags.inexact;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed-vector bench for fp32_mul_seq: table of hand-computed products plus
// backpressure and mid-operation reset sequences.
module tb_fp32_mul_seq;

  localparam int BPC   = 1;
  localparam int LAT_N = 24 / BPC + 1;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        exc_invalid;
  logic        exc_overflow;
  logic        exc_underflow;
  logic        exc_inexact;
  logic        busy;

  always #5 clk = ~clk;

  fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .exc_invalid(exc_invalid), .exc_overflow(exc_overflow),
    .exc_underflow(exc_underflow), .exc_inexact(exc_inexact),
    .busy(busy)
  );

  // flags packed as {invalid, overflow, underflow, inexact}
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [3:0] flags_now();
    return {exc_invalid, exc_overflow, exc_underflow, exc_inexact};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [31:0] ey, input logic [3:0] ef, input int el);
    vec_t v;
    v.name = name; v.a = ia; v.b = ib; v.y = ey; v.f = ef; v.lat = el;
    vq.push_back(v);
  endtask

  // Accept one operand pair, return result, flags and cycles from accept edge to out_valid.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] oy, output logic [3:0] of, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < LIMIT) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1; lat++;
    end
    oy = y;
    of = flags_now();
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ry;
    logic [3:0]  rf;
    int          lat;
    logic [31:0] hold_y;
    logic [3:0]  hold_f;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

    add("mul_3x2",          32'h40400000, 32'h40000000, 32'h40c00000, 4'b0000, LAT_N);
    add("inexact_rne",      32'h3f800001, 32'h3f800001, 32'h3f800002, 4'b0001, LAT_N);
    add("overflow",         32'h7f7fffff, 32'h40000000, 32'h7f800000, 4'b0101, LAT_N);
    add("sub_tie_even_0",   32'h00000001, 32'h3f000000, 32'h00000000, 4'b0011, LAT_N);
    add("sub_tie_even_2",   32'h00000003, 32'h3f000000, 32'h00000002, 4'b0011, LAT_N);
    add("inf_x_zero",       32'h7f800000, 32'h80000000, 32'h7fc00000, 4'b1000, 0);
    add("snan_a",           32'h7f800001, 32'h3f800000, 32'h7fc00001, 4'b1000, 0);
    add("qnan_a_snan_b",    32'h7fc00000, 32'h7f800001, 32'h7fc00000, 4'b1000, 0);
    add("inf_x_finite",     32'hff800000, 32'h40000000, 32'hff800000, 4'b0000, 0);
    add("neg_zero",         32'h80000000, 32'h3f800000, 32'h80000000, 4'b0000, 0);
    add("neg_product",      32'hc0000000, 32'h40400000, 32'hc0c00000, 4'b0000, LAT_N);
    add("sub_to_min_norm",  32'h00400000, 32'h40000000, 32'h00800000, 4'b0000, LAT_N);
    add("norm_to_sub_exact",32'h00800000, 32'h3f000000, 32'h00400000, 4'b0000, LAT_N);
    add("sub_round_to_norm",32'h007fffff, 32'h3f800001, 32'h00800000, 4'b0011, LAT_N);
    add("round_carry",      32'h3f800001, 32'h3f7ffffe, 32'h3f800000, 4'b0001, LAT_N);
    add("p47_set",          32'h3f7fffff, 32'h3f7fffff, 32'h3f7ffffe, 4'b0001, LAT_N);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_in_ready",  32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy), 32'd0);
    check("reset_y",         y, 32'd0);
    check("reset_flags",     32'(flags_now()), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      do_op(vq[i].a, vq[i].b, ry, rf, lat);
      check({vq[i].name, "_y"},       ry, vq[i].y);
      check({vq[i].name, "_flags"},   32'(rf), 32'(vq[i].f));
      check({vq[i].name, "_latency"}, 32'(lat), 32'(vq[i].lat));
      ack();
      check({vq[i].name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      check({vq[i].name, "_in_ready_back"},  32'(in_ready), 32'd1);
    end

    // Backpressure: result must hold while out_ready stays low.
    do_op(32'h7f7fffff, 32'h40000000, hold_y, hold_f, lat);
    check("bp_y_initial", hold_y, 32'h7f800000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_y_hold",     y, 32'h7f800000);
      check("bp_flags_hold", 32'(flags_now()), 32'(4'b0101));
      check("bp_out_valid",  32'(out_valid), 32'd1);
      check("bp_in_ready",   32'(in_ready), 32'd0);
    end
    // in_valid during the DONE handshake must not start a new operation that cycle.
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    ack();
    check("no_accept_on_done_busy",     32'(busy), 32'd0);
    check("no_accept_on_done_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Reset pulsed mid-MUL.
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_reset_in_ready",  32'(in_ready), 32'd1);
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_busy",      32'(busy), 32'd0);
    check("mid_reset_y",         y, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_op(32'h3f800001, 32'h3f800001, ry, rf, lat);
    check("post_reset_y",       ry, 32'h3f800002);
    check("post_reset_flags",   32'(rf), 32'(4'b0001));
    check("post_reset_latency", 32'(lat), 32'(LAT_N));
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
